matrix_mac_sequencer: RTL and testbench

Initiator side of the matrix element fetch interface. It walks (i,j,k) over C = A x B, drives ena/i/j/k to the combinational fetch block, and consumes the returned Aik/Bkj in the same cycle. It multiply-accumulates each dot product and emits one result-write per C element into the result store. It sits between the top-level convolution controller (start/done) and the fetch block and result memory.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_mac_unit.sv | 35 +++
 rtl/matrix_mac_sequencer.sv | 138 +++++++++++++
 tb/tb_matrix_mac_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix MAC sequencer.
// Sequencer states and index-width sizing.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } mms_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_mac_unit.sv
// Signed multiply-accumulate slice for one dot product.
// sum is the value the accumulator takes this cycle.
import matrix_pkg::*;

module matrix_mac_unit #(
  parameter int WIDTH_BIT = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic                        first,
  input  logic signed [WIDTH_BIT-1:0] a,
  input  logic signed [WIDTH_BIT-1:0] b,
  output logic signed [WIDTH_BIT-1:0] sum
);

  logic signed [WIDTH_BIT-1:0] prod;
  logic signed [WIDTH_BIT-1:0] acc;

  // product keeps only the low WIDTH_BIT bits
  assign prod = a * b;
  assign sum  = first ? prod : acc + prod;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Walks (i,j,k) over C = A x B, accumulates each dot
// product and writes one C element per completed sum.
import matrix_pkg::*;

module matrix_mac_sequencer #(
  parameter int AROWS     = 3,
  parameter int ACOLUMNS  = 3,
  parameter int BCOLUMNS  = 3,
  parameter int WIDTH_BIT = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic                        ena,
  output logic [WIDTH_BIT-1:0]        i,
  output logic [WIDTH_BIT-1:0]        j,
  output logic [WIDTH_BIT-1:0]        k,
  input  logic signed [WIDTH_BIT-1:0] Aik,
  input  logic signed [WIDTH_BIT-1:0] Bkj,
  output logic                        working,
  output logic                        c_wr_en,
  output logic [WIDTH_BIT-1:0]        c_row,
  output logic [WIDTH_BIT-1:0]        c_col,
  output logic signed [WIDTH_BIT-1:0] c_data,
  output logic                        done
);

  localparam int IW = idx_w(AROWS);
  localparam int JW = idx_w(BCOLUMNS);
  localparam int KW = idx_w(ACOLUMNS);

  localparam logic [IW-1:0] ILAST = IW'(AROWS - 1);
  localparam logic [JW-1:0] JLAST = JW'(BCOLUMNS - 1);
  localparam logic [KW-1:0] KLAST = KW'(ACOLUMNS - 1);

  mms_state_t state, nstate;

  logic [IW-1:0] ic;
  logic [JW-1:0] jc;
  logic [KW-1:0] kc;

  logic run, iend, jend, kend, last, wr_go;
  logic signed [WIDTH_BIT-1:0] sum;

  assign run   = (state == RUN);
  assign iend  = (ic == ILAST);
  assign jend  = (jc == JLAST);
  assign kend  = (kc == KLAST);
  assign last  = iend && jend && kend;
  assign wr_go = run && kend && !abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) nstate = RUN;
      end
      RUN: begin
        if (abort) nstate = IDLE;
        else if (last) nstate = DRAIN;
      end
      DRAIN: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // k innermost, then j, then i; counters rest at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ic <= '0;
      jc <= '0;
      kc <= '0;
    end else if (!run || abort) begin
      ic <= '0;
      jc <= '0;
      kc <= '0;
    end else begin
      kc <= kend ? '0 : kc + KW'(1);
      if (kend) begin
        jc <= jend ? '0 : jc + JW'(1);
      end
      if (kend && jend) begin
        ic <= iend ? '0 : ic + IW'(1);
      end
    end
  end

  matrix_mac_unit #(
    .WIDTH_BIT(WIDTH_BIT)
  ) u_mac (
    .clock(clock),
    .reset(reset),
    .clear(!run || abort),
    .en   (run),
    .first(kc == '0),
    .a    (Aik),
    .b    (Bkj),
    .sum  (sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_wr_en <= 1'b0;
      done    <= 1'b0;
      c_row   <= '0;
      c_col   <= '0;
      c_data  <= '0;
    end else begin
      c_wr_en <= wr_go;
      done    <= wr_go && iend && jend;
      if (wr_go) begin
        c_row  <= WIDTH_BIT'(ic);
        c_col  <= WIDTH_BIT'(jc);
        c_data <= sum;
      end
    end
  end

  assign ena     = run;
  assign working = run || (state == DRAIN);
  assign i       = run ? WIDTH_BIT'(ic) : '0;
  assign j       = run ? WIDTH_BIT'(jc) : '0;
  assign k       = run ? WIDTH_BIT'(kc) : '0;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Randomized and directed bench for matrix_mac_sequencer
// against a plain-arithmetic matrix product model.
module tb_matrix_mac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ena, working, c_wr_en, done;
  logic [31:0] i, j, k, c_row, c_col;
  logic signed [31:0] aik, bkj, c_data;

  logic start2 = 1'b0;
  logic abort2 = 1'b0;
  logic ena2, working2, c_wr_en2, done2;
  logic [31:0] i2, j2, k2, c_row2, c_col2;
  logic signed [31:0] aik2, bkj2, c_data2;

  logic signed [31:0] am[3][3];
  logic signed [31:0] bm[3][3];
  logic signed [31:0] cm[3][3];
  logic signed [31:0] a2[2];
  logic signed [31:0] b2[2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign aik  = ena ? am[i[1:0]][k[1:0]] : 32'sd0;
  assign bkj  = ena ? bm[k[1:0]][j[1:0]] : 32'sd0;
  assign aik2 = ena2 ? a2[i2[0]] : 32'sd0;
  assign bkj2 = ena2 ? b2[j2[0]] : 32'sd0;

  matrix_mac_sequencer dut (
    .clock(clk), .reset(rst), .start(start), .abort(abort),
    .ena(ena), .i(i), .j(j), .k(k), .Aik(aik), .Bkj(bkj),
    .working(working), .c_wr_en(c_wr_en), .c_row(c_row),
    .c_col(c_col), .c_data(c_data), .done(done)
  );

  matrix_mac_sequencer #(
    .AROWS(2), .ACOLUMNS(1), .BCOLUMNS(2), .WIDTH_BIT(32)
  ) dut2 (
    .clock(clk), .reset(rst), .start(start2), .abort(abort2),
    .ena(ena2), .i(i2), .j(j2), .k(k2), .Aik(aik2), .Bkj(bkj2),
    .working(working2), .c_wr_en(c_wr_en2), .c_row(c_row2),
    .c_col(c_col2), .c_data(c_data2), .done(done2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic void calc();
    logic signed [31:0] s;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int m = 0; m < 3; m++) s = s + am[r][m] * bm[m][c];
        cm[r][c] = s;
      end
  endfunction

  task automatic idle_chk(input string tag);
    check({tag, ".ena"}, {31'b0, ena}, 0);
    check({tag, ".working"}, {31'b0, working}, 0);
    check({tag, ".wr"}, {31'b0, c_wr_en}, 0);
    check({tag, ".done"}, {31'b0, done}, 0);
    check({tag, ".i"}, i, 0);
    check({tag, ".k"}, k, 0);
  endtask

  // cycle c is the period after edge c-1; start sampled at edge 0
  task automatic run_mm(input int abort_at, input int p1,
                        input int p2, input int rst_at);
    int nn, m, e, wr, dn, ewr, edn;
    bit live, r, ew;
    nn = 27; wr = 0; dn = 0; ewr = 0; edn = 0;
    calc();
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= nn + 4; c++) begin
      @(negedge clk);
      live = !(abort_at > 0 && c > abort_at);
      r = live && c <= nn;
      m = c - 1;
      ew = live && c >= 4 && c <= nn + 1 && (m % 3) == 0;
      check("ena", {31'b0, ena}, {31'b0, r});
      check("working", {31'b0, working},
            {31'b0, live && c <= nn + 1});
      check("c_wr_en", {31'b0, c_wr_en}, {31'b0, ew});
      check("done", {31'b0, done}, {31'b0, live && c == nn + 1});
      check("i", i, r ? m / 9 : 0);
      check("j", j, r ? (m / 3) % 3 : 0);
      check("k", k, r ? m % 3 : 0);
      if (ew) begin
        e = m / 3 - 1;
        ewr++;
        check("c_row", c_row, e / 3);
        check("c_col", c_col, e % 3);
        check("c_data", c_data, cm[e / 3][e % 3]);
      end
      if (live && c == nn + 1) edn++;
      if (c_wr_en) wr++;
      if (done) dn++;
      start = (c == p1 || c == p2);
      abort = (c == abort_at);
      if (c == rst_at) begin
        #1 rst = 1'b1;
        #1 idle_chk("async_rst");
        check("rst.c_data", c_data, 0);
        check("rst.c_row", c_row, 0);
        check("rst.c_col", c_col, 0);
        rst = 1'b0;
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check("n_writes", wr, ewr);
    check("n_done", dn, edn);
    repeat (2) @(negedge clk);
    idle_chk("after");
  endtask

  task automatic fill(input bit full);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        am[r][c] = full ? $urandom : $urandom_range(200) - 100;
        bm[r][c] = full ? $urandom : $urandom_range(200) - 100;
      end
  endtask

  initial begin
    fill(0);
    for (int q = 0; q < 2; q++) begin
      a2[q] = $urandom_range(2000) - 1000;
      b2[q] = $urandom_range(2000) - 1000;
    end
    #2 idle_chk("reset");
    check("reset.c_data", c_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        am[r][c] = r * 3 + c + 1;
        bm[r][c] = (r == c) ? 1 : 0;
      end
    run_mm(0, 0, 0, 0);

    fill(0);
    am[0][0] = -1; am[0][1] = 2; am[0][2] = -3;
    bm[0][0] = 4;  bm[1][0] = 5; bm[2][0] = 6;
    run_mm(0, 0, 0, 0);

    for (int m = 0; m < 3; m++) begin
      am[0][m] = 32'sh7FFFFFFF;
      bm[m][0] = 1;
    end
    run_mm(0, 0, 0, 0);

    fill(0);
    run_mm(10, 0, 0, 0);
    run_mm(0, 0, 0, 0);
    run_mm(0, 5, 28, 0);
    run_mm(0, 0, 0, 15);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    idle_chk("abort_start");

    for (int t = 0; t < 3; t++) begin
      fill(1);
      run_mm(0, 0, 0, 0);
    end

    // 2x1 by 1x2: a write every cycle 2..5
    @(negedge clk);
    start2 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      check("d2.working", {31'b0, working2},
            {31'b0, c >= 1 && c <= 5});
      check("d2.wr", {31'b0, c_wr_en2}, {31'b0, c >= 2 && c <= 5});
      check("d2.done", {31'b0, done2}, {31'b0, c == 5});
      if (c >= 2 && c <= 5) begin
        check("d2.row", c_row2, (c - 2) / 2);
        check("d2.col", c_col2, (c - 2) % 2);
        check("d2.data", c_data2, a2[(c - 2) / 2] * b2[(c - 2) % 2]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
